// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I decoder/ALU slice: 7-bit opcode values,
// funct3 encodings for the ALU and for branches, and the internal ALU
// operation enum.
// No ports (package).
// Optional build macro used by files that import this package:
//   ILLEGAL_INSTR_EN - enables the is_illegal decode output.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN = 32;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3 (consumed by the core FSM together with eq/lt/ltu)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/rv32i_decode_alu_if.sv
// ---------------------------------------------------------------------------
// rv32i_decode_alu_if
// Bundles the decoder/ALU request and result signals.
//   master: drives in_valid/instr/rs1_data/rs2_data, observes decode + result
//   slave : the rv32i_decode_alu block
// ILLEGAL_INSTR_EN adds the is_illegal signal.
// ---------------------------------------------------------------------------
interface rv32i_decode_alu_if;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        is_alu_reg, is_alu_imm, is_load, is_store, is_lui;
  logic        is_auipc, is_jal, is_jalr, is_system, is_branch;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        out_valid;
  logic [31:0] alu_out;
  logic        eq, lt, ltu;
`ifdef ILLEGAL_INSTR_EN
  logic        is_illegal;
`endif

  modport master (
`ifdef ILLEGAL_INSTR_EN
    input  is_illegal,
`endif
    output in_valid, instr, rs1_data, rs2_data,
    input  is_alu_reg, is_alu_imm, is_load, is_store, is_lui,
    input  is_auipc, is_jal, is_jalr, is_system, is_branch,
    input  rd, rs1, rs2, funct3, funct7,
    input  imm_i, imm_s, imm_b, imm_u, imm_j,
    input  out_valid, alu_out, eq, lt, ltu
  );

  modport slave (
`ifdef ILLEGAL_INSTR_EN
    output is_illegal,
`endif
    input  in_valid, instr, rs1_data, rs2_data,
    output is_alu_reg, is_alu_imm, is_load, is_store, is_lui,
    output is_auipc, is_jal, is_jalr, is_system, is_branch,
    output rd, rs1, rs2, funct3, funct7,
    output imm_i, imm_s, imm_b, imm_u, imm_j,
    output out_valid, alu_out, eq, lt, ltu
  );
endinterface

// File: rtl/rv32i_decoder.sv
// ---------------------------------------------------------------------------
// rv32i_decoder
// Purely combinational RV32I decode: one-hot class flags, register fields,
// function codes and the five sign-extended immediate formats.
// Ports: i_instr (32) in; o_is_* class flags, o_rd/o_rs1/o_rs2 (5),
//        o_funct3 (3), o_funct7 (7), o_imm_i/s/b/u/j (32) out.
// ILLEGAL_INSTR_EN adds o_is_illegal.
// ---------------------------------------------------------------------------
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_is_alu_reg, o_is_alu_imm, o_is_load, o_is_store, o_is_lui,
  output logic        o_is_auipc, o_is_jal, o_is_jalr, o_is_system, o_is_branch,
  output logic [4:0]  o_rd, o_rs1, o_rs2,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [31:0] o_imm_i, o_imm_s, o_imm_b, o_imm_u, o_imm_j
`ifdef ILLEGAL_INSTR_EN
  ,
  output logic        o_is_illegal
`endif
);

  logic [6:0] w_opcode;
  logic       w_sign;

  assign w_opcode = i_instr[6:0];
  assign w_sign   = i_instr[31];

  assign o_rd     = i_instr[11:7];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  assign o_funct3 = i_instr[14:12];
  assign o_funct7 = i_instr[31:25];

  assign o_imm_i = {{20{w_sign}}, i_instr[31:20]};
  assign o_imm_s = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
  assign o_imm_b = {{20{w_sign}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign o_imm_u = {i_instr[31:12], 12'h000};
  assign o_imm_j = {{12{w_sign}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Opcode to one-hot class flag; unknown opcodes leave every flag low
  always_comb begin
    o_is_alu_reg = 1'b0;
    o_is_alu_imm = 1'b0;
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    o_is_lui     = 1'b0;
    o_is_auipc   = 1'b0;
    o_is_jal     = 1'b0;
    o_is_jalr    = 1'b0;
    o_is_system  = 1'b0;
    o_is_branch  = 1'b0;
    case (w_opcode)
      OP_ALU_REG: o_is_alu_reg = 1'b1;
      OP_ALU_IMM: o_is_alu_imm = 1'b1;
      OP_LOAD:    o_is_load    = 1'b1;
      OP_STORE:   o_is_store   = 1'b1;
      OP_LUI:     o_is_lui     = 1'b1;
      OP_AUIPC:   o_is_auipc   = 1'b1;
      OP_JAL:     o_is_jal     = 1'b1;
      OP_JALR:    o_is_jalr    = 1'b1;
      OP_BRANCH:  o_is_branch  = 1'b1;
      OP_SYSTEM:  o_is_system  = 1'b1;
      default:    o_is_alu_reg = 1'b0;
    endcase
  end

`ifdef ILLEGAL_INSTR_EN
  logic w_any_class;

  assign w_any_class = o_is_alu_reg | o_is_alu_imm | o_is_load | o_is_store | o_is_lui |
                       o_is_auipc | o_is_jal | o_is_jalr | o_is_system | o_is_branch;

  // Illegal: non-32-bit encoding, unknown opcode, or a bad ALUreg funct7.
  // funct7=0100000 is only meaningful for SUB (000) and SRA (101).
  always_comb begin
    o_is_illegal = 1'b0;
    if (i_instr[1:0] != 2'b11) begin
      o_is_illegal = 1'b1;
    end else if (!w_any_class) begin
      o_is_illegal = 1'b1;
    end else if (o_is_alu_reg) begin
      if (o_funct7 == 7'b0000000) begin
        o_is_illegal = 1'b0;
      end else if (o_funct7 == 7'b0100000) begin
        o_is_illegal = !((o_funct3 == F3_ADD) || (o_funct3 == F3_SR));
      end else begin
        o_is_illegal = 1'b1;
      end
    end else begin
      o_is_illegal = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/rv32i_decode_alu.sv
// ---------------------------------------------------------------------------
// rv32i_decode_alu
// RV32I decoder (combinational outputs) plus integer ALU whose result and
// compare flags are registered with one cycle of latency.
// Ports: clock, reset (synchronous, active-high);
//        bus (rv32i_decode_alu_if.slave): in_valid, instr, rs1_data,
//        rs2_data in; decode flags/fields/immediates (comb), out_valid,
//        alu_out, eq, lt, ltu (registered) out.
// Build macro ILLEGAL_INSTR_EN adds bus.is_illegal (comb).
// ---------------------------------------------------------------------------
module rv32i_decode_alu
  import rv32i_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic               clock,
  input  logic               reset,
  rv32i_decode_alu_if.slave  bus
);

  logic [WIDTH-1:0] w_op2;
  logic [4:0]       w_shamt;
  logic             w_eq, w_lt, w_ltu;
  alu_op_e          w_alu_op;
  logic [WIDTH-1:0] w_alu_result;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_eq, r_lt, r_ltu;

  rv32i_decoder u_decoder (
    .i_instr      (bus.instr),
    .o_is_alu_reg (bus.is_alu_reg),
    .o_is_alu_imm (bus.is_alu_imm),
    .o_is_load    (bus.is_load),
    .o_is_store   (bus.is_store),
    .o_is_lui     (bus.is_lui),
    .o_is_auipc   (bus.is_auipc),
    .o_is_jal     (bus.is_jal),
    .o_is_jalr    (bus.is_jalr),
    .o_is_system  (bus.is_system),
    .o_is_branch  (bus.is_branch),
    .o_rd         (bus.rd),
    .o_rs1        (bus.rs1),
    .o_rs2        (bus.rs2),
    .o_funct3     (bus.funct3),
    .o_funct7     (bus.funct7),
    .o_imm_i      (bus.imm_i),
    .o_imm_s      (bus.imm_s),
    .o_imm_b      (bus.imm_b),
    .o_imm_u      (bus.imm_u),
    .o_imm_j      (bus.imm_j)
`ifdef ILLEGAL_INSTR_EN
    ,
    .o_is_illegal (bus.is_illegal)
`endif
  );

  // Register operand for R-type and branches, I-immediate otherwise
  assign w_op2   = (bus.is_alu_reg | bus.is_branch) ? bus.rs2_data : bus.imm_i;
  assign w_shamt = w_op2[4:0];
  assign w_eq    = (bus.rs1_data == w_op2);
  assign w_lt    = ($signed(bus.rs1_data) < $signed(w_op2));
  assign w_ltu   = (bus.rs1_data < w_op2);

  // Map funct3/funct7 to an ALU operation. SUB only exists in R-form
  // (ADDI's funct7 bits are immediate), while SRA/SRAI share funct7[5].
  always_comb begin
    w_alu_op = ALU_ADD;
    case (bus.funct3)
      F3_ADD: begin
        if (bus.is_alu_reg && bus.funct7[5]) begin
          w_alu_op = ALU_SUB;
        end else begin
          w_alu_op = ALU_ADD;
        end
      end
      F3_SLL:  w_alu_op = ALU_SLL;
      F3_SLT:  w_alu_op = ALU_SLT;
      F3_SLTU: w_alu_op = ALU_SLTU;
      F3_XOR:  w_alu_op = ALU_XOR;
      F3_SR: begin
        if (bus.funct7[5]) begin
          w_alu_op = ALU_SRA;
        end else begin
          w_alu_op = ALU_SRL;
        end
      end
      F3_OR:   w_alu_op = ALU_OR;
      F3_AND:  w_alu_op = ALU_AND;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  // ALU datapath, modulo 2^WIDTH
  always_comb begin
    w_alu_result = {WIDTH{1'b0}};
    case (w_alu_op)
      ALU_ADD:  w_alu_result = bus.rs1_data + w_op2;
      ALU_SUB:  w_alu_result = bus.rs1_data - w_op2;
      ALU_SLL:  w_alu_result = bus.rs1_data << w_shamt;
      ALU_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, w_ltu};
      ALU_XOR:  w_alu_result = bus.rs1_data ^ w_op2;
      ALU_SRL:  w_alu_result = bus.rs1_data >> w_shamt;
      ALU_SRA:  w_alu_result = $unsigned($signed(bus.rs1_data) >>> w_shamt);
      ALU_OR:   w_alu_result = bus.rs1_data | w_op2;
      ALU_AND:  w_alu_result = bus.rs1_data & w_op2;
      default:  w_alu_result = {WIDTH{1'b0}};
    endcase
  end

  // Result register: reset beats in_valid; data and flags hold when idle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_out   <= {WIDTH{1'b0}};
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_ltu       <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_alu_out <= w_alu_result;
        r_eq      <= w_eq;
        r_lt      <= w_lt;
        r_ltu     <= w_ltu;
      end else begin
        r_alu_out <= r_alu_out;
        r_eq      <= r_eq;
        r_lt      <= r_lt;
        r_ltu     <= r_ltu;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.alu_out   = r_alu_out;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;
  assign bus.ltu       = r_ltu;

endmodule

// File: tb/tb_rv32i_decode_alu.sv
// ---------------------------------------------------------------------------
// tb_rv32i_decode_alu
// Directed self-checking bench for rv32i_decode_alu with hand-computed
// expected values. Inputs change 1 ns after the rising edge; registered
// outputs are sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_rv32i_decode_alu;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fails;

  rv32i_decode_alu_if bus_if ();

  rv32i_decode_alu #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  // Free-running 100 MHz clock
  always #5 clock = ~clock;

  // Compare one observed value against its expected value
  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks = n_checks + 1;
    if (observed !== expected) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Class flags packed as {alu_reg, alu_imm, load, store, lui, auipc, jal, jalr, system, branch}
  function automatic logic [31:0] class_flags();
    return {22'd0, bus_if.is_alu_reg, bus_if.is_alu_imm, bus_if.is_load, bus_if.is_store,
            bus_if.is_lui, bus_if.is_auipc, bus_if.is_jal, bus_if.is_jalr,
            bus_if.is_system, bus_if.is_branch};
  endfunction

  function automatic logic [31:0] cmp_flags();
    return {29'd0, bus_if.eq, bus_if.lt, bus_if.ltu};
  endfunction

  // Launch one operation and check the registered result one edge later
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_alu, input logic [2:0] exp_cmp);
    bus_if.in_valid = 1'b1;
    bus_if.instr    = ins;
    bus_if.rs1_data = a;
    bus_if.rs2_data = b;
    @(posedge clock);
    #1;
    check_val({tag, "_valid"}, {31'd0, bus_if.out_valid}, 32'd1);
    check_val({tag, "_alu"}, bus_if.alu_out, exp_alu);
    check_val({tag, "_cmp"}, cmp_flags(), {29'd0, exp_cmp});
  endtask

  logic [6:0] opcodes [10];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clock    = 1'b0;
    reset    = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.instr    = 32'h0000_0000;
    bus_if.rs1_data = 32'h0000_0000;
    bus_if.rs2_data = 32'h0000_0000;
    opcodes = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011, 7'b1100011};

    repeat (2) @(posedge clock);
    #1;
    check_val("rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_val("rst_alu", bus_if.alu_out, 32'd0);
    check_val("rst_cmp", cmp_flags(), 32'd0);
    reset = 1'b0;

    // add x3,x1,x2
    run_op("add", 32'h0020_81B3, 32'd5, 32'd7, 32'd12, 3'b011);
    check_val("add_class", class_flags(), 32'h0000_0200);
    check_val("add_rd", {27'd0, bus_if.rd}, 32'd3);
    check_val("add_rs1", {27'd0, bus_if.rs1}, 32'd1);
    check_val("add_rs2", {27'd0, bus_if.rs2}, 32'd2);

    // sub, back-to-back
    run_op("sub", 32'h4020_81B3, 32'd5, 32'd7, 32'hFFFF_FFFE, 3'b011);
    check_val("sub_f7", {25'd0, bus_if.funct7}, 32'h0000_0020);

    // addi x1,x0,-1 : funct7 bits are immediate, must still add
    run_op("addi", 32'hFFF0_0093, 32'd100, 32'd0, 32'd99, 3'b001);
    check_val("addi_imm_i", bus_if.imm_i, 32'hFFFF_FFFF);
    check_val("addi_class", class_flags(), 32'h0000_0100);

    // srai / srli x1,x2,4
    run_op("srai", 32'h4041_5093, 32'h8000_0000, 32'd0, 32'hF800_0000, 3'b010);
    run_op("srli", 32'h0041_5093, 32'h8000_0000, 32'd0, 32'h0800_0000, 3'b010);

    // Remaining R-type funct3 codes, rs1=0x8000000F rs2=0x21 (shamt 1)
    run_op("sll",  32'h0020_91B3, 32'h8000_000F, 32'h0000_0021, 32'h0000_001E, 3'b010);
    run_op("slt",  32'h0020_A1B3, 32'h8000_000F, 32'h0000_0021, 32'h0000_0001, 3'b010);
    run_op("sltu", 32'h0020_B1B3, 32'h8000_000F, 32'h0000_0021, 32'h0000_0000, 3'b010);
    run_op("xor",  32'h0020_C1B3, 32'h8000_000F, 32'h0000_0021, 32'h8000_002E, 3'b010);
    run_op("srl",  32'h0020_D1B3, 32'h8000_000F, 32'h0000_0021, 32'h4000_0007, 3'b010);
    run_op("sra",  32'h4020_D1B3, 32'h8000_000F, 32'h0000_0021, 32'hC000_0007, 3'b010);
    run_op("or",   32'h0020_E1B3, 32'h8000_000F, 32'h0000_0021, 32'h8000_002F, 3'b010);
    run_op("and",  32'h0020_F1B3, 32'h8000_000F, 32'h0000_0021, 32'h0000_0001, 3'b010);

    // blt x1,x2 : op2 comes from rs2, -1 < 1 signed but not unsigned
    run_op("blt", 32'h0020_C063, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 3'b010);
    check_val("blt_class", class_flags(), 32'h0000_0001);

    // Idle cycle: result and flags hold; decode jal meanwhile
    bus_if.in_valid = 1'b0;
    bus_if.instr    = 32'h0080_00EF;
    #1;
    check_val("jal_class", class_flags(), 32'h0000_0008);
    check_val("jal_imm_j", bus_if.imm_j, 32'd8);
    check_val("jal_rd", {27'd0, bus_if.rd}, 32'd1);
    @(posedge clock);
    #1;
    check_val("idle_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_val("idle_alu", bus_if.alu_out, 32'hFFFF_FFFE);
    check_val("idle_cmp", cmp_flags(), 32'h0000_0002);

    // lui x5,0x12345
    bus_if.instr = 32'h1234_52B7;
    #1;
    check_val("lui_imm_u", bus_if.imm_u, 32'h1234_5000);
    check_val("lui_rd", {27'd0, bus_if.rd}, 32'd5);
    check_val("lui_class", class_flags(), 32'h0000_0020);

    // Store with all-ones S immediate; B immediate from the same bits
    bus_if.instr = 32'hFE00_0FA3;
    #1;
    check_val("st_imm_s", bus_if.imm_s, 32'hFFFF_FFFF);
    check_val("st_imm_b", bus_if.imm_b, 32'hFFFF_FFFE);
    bus_if.instr = 32'h0000_0463;
    #1;
    check_val("br_imm_b", bus_if.imm_b, 32'd8);

    // Unknown opcode: no class flag
    bus_if.instr = 32'h0000_0000;
    #1;
    check_val("unk_class", class_flags(), 32'd0);

    // One-hot flag per listed opcode
    for (int i = 0; i < 10; i++) begin
      bus_if.instr = {25'd0, opcodes[i]};
      #1;
      check_val($sformatf("op%0d_class", i), class_flags(), 32'd1 << (9 - i));
    end

    // Equal operands on a branch
    run_op("beq_eq", 32'h0020_C063, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 3'b100);

`ifdef ILLEGAL_INSTR_EN
    bus_if.instr = 32'h4020_91B3;
    #1;
    check_val("ill_f7", {31'd0, bus_if.is_illegal}, 32'd1);
    bus_if.instr = 32'h4020_81B3;
    #1;
    check_val("ill_sub", {31'd0, bus_if.is_illegal}, 32'd0);
`endif

    // Reset in the same cycle as in_valid drops the operation
    reset           = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.instr    = 32'h0020_81B3;
    bus_if.rs1_data = 32'd5;
    bus_if.rs2_data = 32'd7;
    @(posedge clock);
    #1;
    check_val("rstv_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_val("rstv_alu", bus_if.alu_out, 32'd0);
    check_val("rstv_cmp", cmp_flags(), 32'd0);
    check_val("rstv_rd", {27'd0, bus_if.rd}, 32'd3);
    reset = 1'b0;

    // Recovery after reset
    run_op("post_rst", 32'h0020_81B3, 32'd1, 32'd2, 32'd3, 3'b011);
    bus_if.in_valid = 1'b0;
    @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_alu.md
Name: rv32i_decode_alu

Overview:
- Combined instruction decoder and integer ALU for the RV32I multi-cycle softcore.
- Decodes a 32-bit instruction into class flags, register indices, function codes and sign-extended immediates; these outputs are combinational.
- Computes the ALU result and branch compare flags, registered with one-cycle latency.
- Sits between instruction fetch (BRAM) and the core FSM's execute/write-back stages.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instr/operands valid this cycle; launches an ALU operation
- instr  in  32  instruction word
- rs1_data  in  32  register-file value of rs1
- rs2_data  in  32  register-file value of rs2
- is_alu_reg, is_alu_imm, is_load, is_store, is_lui, is_auipc, is_jal, is_jalr, is_system, is_branch  out  1 each  class flags (comb)
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20] (comb)
- funct3  out  3  instr[14:12] (comb)
- funct7  out  7  instr[31:25] (comb)
- imm_i, imm_s, imm_b, imm_u, imm_j  out  32 each  immediates (comb)
- out_valid  out  1  registered result valid
- alu_out  out  32  registered ALU result
- eq, lt, ltu  out  1 each  registered compare flags

Behaviour:
- Opcodes (instr[6:0]) set the flags, at most one asserted:
  - 0110011 ALUreg; 0010011 ALUimm; 0000011 Load; 0100011 Store
  - 0110111 LUI; 0010111 AUIPC; 1101111 JAL; 1100111 JALR
  - 1100011 Branch; 1110011 System
  - Any other opcode: all flags 0.
- Immediates, all sign-extended from instr[31]:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- op2 = rs2_data if (is_alu_reg | is_branch), else imm_i.
- funct3 operations:
  - 000: ADD; SUB when is_alu_reg & funct7[5]. ADDI ignores funct7.
  - 001: SLL by op2[4:0]
  - 010: SLT (signed), result 0/1
  - 011: SLTU, result 0/1
  - 100: XOR
  - 101: SRL; SRA when funct7[5]. Applies to both reg and imm forms.
  - 110: OR
  - 111: AND
- Arithmetic is modulo 2^32; overflow is ignored; shift amounts use only 5 bits.
- eq = (rs1_data == op2); lt = signed(rs1_data) < signed(op2); ltu = unsigned compare.
- ALU is evaluated for any in_valid regardless of class; the consumer ignores unused results.
- Timing: in_valid at edge N -> out_valid=1 with alu_out/eq/lt/ltu at edge N+1.
  - Without in_valid: out_valid=0 next cycle; alu_out and flags hold their previous values.
  - Back-to-back in_valid gives back-to-back results.
- Reset: out_valid=0, alu_out=0, eq=lt=ltu=0.
  - Reset in the same cycle as in_valid wins; the operation is dropped.
  - Combinational outputs are unaffected by reset.

Optional Feature:
- Macro ILLEGAL_INSTR_EN.
- Defined: adds output is_illegal (1 bit, comb). Asserted when instr[1:0] != 2'b11 or no opcode flag matches. Also asserted for ALUreg with funct7 other than 0000000/0100000, or with 0100000 on funct3 not in {000, 101}.
- Undefined: port is absent and no checking logic exists.

Decomposition:
- Package rv32i_pkg: opcode localparams (7-bit), funct3 encodings for ALU and branch, alu_op enum.
- Sub-module rv32i_decoder (purely combinational: flags, fields, immediates).
- Top module holds the ALU datapath and result register.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> is_alu_reg=1, rd=3, rs1=1, rs2=2; next cycle out_valid=1, alu_out=12.
- sub (0x402081B3), rs1=5, rs2=7 -> alu_out=0xFFFFFFFE; then addi x1,x0,-1 (0xFFF00093) -> imm_i=0xFFFFFFFF, alu_out=rs1_data-1.
- srai x1,x2,4 (0x40415093), rs1=0x80000000 -> alu_out=0xF8000000; srli (0x00415093) -> 0x08000000.
- blt x1,x2 (funct3=100, is_branch), rs1=0xFFFFFFFF, rs2=1 -> lt=1, ltu=0, eq=0; equal operands -> eq=1.
- jal x1,8 (0x008000EF) -> is_jal=1, imm_j=8, rd=1; lui x5,0x12345 (0x123452B7) -> imm_u=0x12345000.
- reset asserted with in_valid -> out_valid=0, alu_out=0 next cycle; unknown opcode 0x00000000 -> all class flags 0.
